// File: rtl/stream_mux2_pkg.sv
// Shared encodings for the two-input packet-aware stream merger.
package stream_mux2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOCK_A = 2'b01,
    LOCK_B = 2'b10
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, pointer updated on packet completion.
// advSel names the channel that just finished; the pointer then favours the other one.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic reqA,
  input  logic reqB,
  input  logic advance,
  input  logic advSel,
  output logic grantA,
  output logic grantB
);

  // ptr_q = 0 favours A on a tie, 1 favours B.
  logic ptr_q, ptr_d;

  assign ptr_d  = advance ? ~advSel : ptr_q;
  assign grantA = reqA && (!reqB || !ptr_q);
  assign grantB = reqB && (!reqA ||  ptr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/stream_mux2.sv
// Round-robin 2:1 packet merger with source tag; 1-cycle registered output.
// Backpressure: input readys drop whenever the held output beat is stalled.
module stream_mux2
  import stream_mux2_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inA,
  input  logic             inAValid,
  input  logic             inALast,
  output logic             inAReady,
  input  logic [WIDTH-1:0] inB,
  input  logic             inBValid,
  input  logic             inBLast,
  output logic             inBReady,
  output logic [WIDTH-1:0] out,
  output logic             outValid,
  output logic             outLast,
  output logic             outSel,
  input  logic             outReady
);

  state_e           state_q;
  logic [WIDTH-1:0] out_q;
  logic             out_vld_q;
  logic             out_last_q;
  logic             out_sel_q;

  logic load;
  logic arb_a, arb_b;
  logic grant_a, grant_b;
  logic xfer_a, xfer_b;
  logic adv;

  assign load = !out_vld_q || outReady;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .reqA   (inAValid),
    .reqB   (inBValid),
    .advance(adv),
    .advSel (xfer_b ? SEL_B : SEL_A),
    .grantA (arb_a),
    .grantB (arb_b)
  );

  // A lock pins the grant even while the owning source is momentarily idle.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      IDLE: begin
        grant_a = arb_a;
        grant_b = arb_b;
      end
      LOCK_A:  grant_a = 1'b1;
      LOCK_B:  grant_b = 1'b1;
      default: ;
    endcase
  end

  assign inAReady = rst_n && load && grant_a;
  assign inBReady = rst_n && load && grant_b;
  assign xfer_a   = inAValid && inAReady;
  assign xfer_b   = inBValid && inBReady;
  assign adv      = (xfer_a && inALast) || (xfer_b && inBLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_sel_q  <= SEL_A;
    end else begin
      if (xfer_a) begin
        state_q    <= inALast ? IDLE : LOCK_A;
        out_q      <= inA;
        out_vld_q  <= 1'b1;
        out_last_q <= inALast;
        out_sel_q  <= SEL_A;
      end else if (xfer_b) begin
        state_q    <= inBLast ? IDLE : LOCK_B;
        out_q      <= inB;
        out_vld_q  <= 1'b1;
        out_last_q <= inBLast;
        out_sel_q  <= SEL_B;
      end else if (outReady) begin
        out_vld_q  <= 1'b0;
      end
    end
  end

  assign out      = out_q;
  assign outValid = out_vld_q;
  assign outLast  = out_last_q;
  assign outSel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux2.sv
// Directed bench for stream_mux2: arbitration, locking, stalls, throughput, async reset.
module tb_stream_mux2;

  logic        clk;
  logic        rst_n;
  logic [15:0] inA, inB;
  logic        inAValid, inALast, inAReady;
  logic        inBValid, inBLast, inBReady;
  logic [15:0] out;
  logic        outValid, outLast, outSel, outReady;

  int errors = 0;
  int checks = 0;

  stream_mux2 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inA     (inA),
    .inAValid(inAValid),
    .inALast (inALast),
    .inAReady(inAReady),
    .inB     (inB),
    .inBValid(inBValid),
    .inBLast (inBLast),
    .inBReady(inBReady),
    .out     (out),
    .outValid(outValid),
    .outLast (outLast),
    .outSel  (outSel),
    .outReady(outReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [15:0] d, input logic l);
    inAValid = v; inA = d; inALast = l;
  endtask

  task automatic set_b(input logic v, input logic [15:0] d, input logic l);
    inBValid = v; inB = d; inBLast = l;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] d, input logic sel, input logic l);
    chk({tag, "_vld"},  {31'd0, outValid}, 32'd1);
    chk({tag, "_dat"},  {16'd0, out}, {16'd0, d});
    chk({tag, "_sel"},  {31'd0, outSel}, {31'd0, sel});
    chk({tag, "_last"}, {31'd0, outLast}, {31'd0, l});
  endtask

  task automatic chk_rdy(input string tag, input logic ra, input logic rb);
    chk({tag, "_rdyA"}, {31'd0, inAReady}, {31'd0, ra});
    chk({tag, "_rdyB"}, {31'd0, inBReady}, {31'd0, rb});
  endtask

  initial begin
    // Reset with both sources valid
    rst_n = 1'b0;
    outReady = 1'b1;
    set_a(1'b1, 16'h1111, 1'b1);
    set_b(1'b1, 16'hAAAA, 1'b1);
    tick(); tick(); tick();
    chk("rst_vld", {31'd0, outValid}, 32'd0);
    chk("rst_dat", {16'd0, out}, 32'd0);
    chk("rst_sel", {31'd0, outSel}, 32'd0);
    chk("rst_last", {31'd0, outLast}, 32'd0);
    chk_rdy("rst", 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    #1 chk_rdy("rel", 1'b1, 1'b0);

    // Contention with single-beat packets alternates A/B
    tick(); chk_out("c1", 16'h1111, 1'b0, 1'b1);
    set_a(1'b1, 16'h2222, 1'b1);
    #1 chk_rdy("c1", 1'b0, 1'b1);
    tick(); chk_out("c2", 16'hAAAA, 1'b1, 1'b1);
    set_b(1'b1, 16'hBBBB, 1'b1);
    #1 chk_rdy("c2", 1'b1, 1'b0);
    tick(); chk_out("c3", 16'h2222, 1'b0, 1'b1);
    set_a(1'b0, 16'h0000, 1'b0);
    tick(); chk_out("c4", 16'hBBBB, 1'b1, 1'b1);
    set_b(1'b0, 16'h0000, 1'b0);
    tick(); chk("drain_vld", {31'd0, outValid}, 32'd0);

    // Packet lock: B must wait through A's packet, including A's idle gap
    set_a(1'b1, 16'h0A01, 1'b0);
    set_b(1'b1, 16'h0B01, 1'b1);
    #1 chk_rdy("l0", 1'b1, 1'b0);
    tick(); chk_out("l1", 16'h0A01, 1'b0, 1'b0);
    set_a(1'b1, 16'h0A02, 1'b0);
    #1 chk_rdy("l1", 1'b1, 1'b0);
    tick(); chk_out("l2", 16'h0A02, 1'b0, 1'b0);
    set_a(1'b0, 16'h0000, 1'b0);
    #1 chk_rdy("gap1", 1'b1, 1'b0);
    tick(); chk("gap_vld", {31'd0, outValid}, 32'd0);
    chk_rdy("gap2", 1'b1, 1'b0);
    tick(); chk_rdy("gap3", 1'b1, 1'b0);
    set_a(1'b1, 16'h0A03, 1'b1);
    tick(); chk_out("l3", 16'h0A03, 1'b0, 1'b1);
    set_a(1'b0, 16'h0000, 1'b0);
    #1 chk_rdy("l3", 1'b0, 1'b1);
    tick(); chk_out("l4", 16'h0B01, 1'b1, 1'b1);
    set_b(1'b0, 16'h0000, 1'b0);

    // Backpressure holds the beat and blocks both inputs
    set_a(1'b1, 16'h1234, 1'b1);
    tick(); chk_out("bp0", 16'h1234, 1'b0, 1'b1);
    outReady = 1'b0;
    set_a(1'b1, 16'h5678, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1 chk_rdy("bp", 1'b0, 1'b0);
      tick(); chk_out("bp", 16'h1234, 1'b0, 1'b1);
    end
    outReady = 1'b1;
    #1 chk_rdy("bp_rel", 1'b1, 1'b0);
    tick(); chk_out("bp_next", 16'h5678, 1'b0, 1'b1);
    set_a(1'b0, 16'h0000, 1'b0);
    tick(); chk("bp_drain", {31'd0, outValid}, 32'd0);

    // Back-to-back throughput; B follows A's last beat with no bubble
    set_a(1'b1, 16'h0C01, 1'b0);
    tick(); chk_out("s1", 16'h0C01, 1'b0, 1'b0);
    set_a(1'b1, 16'h0C02, 1'b0);
    set_b(1'b1, 16'h0D01, 1'b1);
    tick(); chk_out("s2", 16'h0C02, 1'b0, 1'b0);
    set_a(1'b1, 16'h0C03, 1'b1);
    tick(); chk_out("s3", 16'h0C03, 1'b0, 1'b1);
    set_a(1'b0, 16'h0000, 1'b0);
    tick(); chk_out("s4", 16'h0D01, 1'b1, 1'b1);
    set_b(1'b0, 16'h0000, 1'b0);

    // Reset mid-packet from B, then A wins a tie
    set_b(1'b1, 16'h0E01, 1'b0);
    tick(); chk_out("m1", 16'h0E01, 1'b1, 1'b0);
    set_b(1'b1, 16'h0E02, 1'b0);
    tick(); chk_out("m2", 16'h0E02, 1'b1, 1'b0);
    set_b(1'b1, 16'h0E03, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vld", {31'd0, outValid}, 32'd0);
    chk("mrst_dat", {16'd0, out}, 32'd0);
    chk("mrst_sel", {31'd0, outSel}, 32'd0);
    chk_rdy("mrst", 1'b0, 1'b0);
    set_a(1'b1, 16'h0F01, 1'b1);
    tick();
    chk("mrst_hold", {31'd0, outValid}, 32'd0);
    #1 rst_n = 1'b1;
    #1 chk_rdy("mrel", 1'b1, 1'b0);
    tick(); chk_out("mrel", 16'h0F01, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
